spi_frame_master: RTL and testbench

- SPI mode-0 frame transmitter: the controller-side counterpart of the CPLD SID register receiver.
- Holds a NUM_REGS x 8 shadow of the SID register file, written by the host-side logic.
- On a trigger, sends the whole shadow as one frame: ss low, bytes in address order 0..NUM_REGS-1, each byte MSB first, then ss high.
- The receiver derives each register address from the byte position in the frame, so no address bits are sent.

---
 rtl/spi_frame_master_if.sv | 24 ++
 rtl/spi_frame_master.sv | 194 +++++++++++++++++++
 tb/tb_spi_frame_master.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_frame_master_if.sv
// Host-side bus of spi_frame_master: shadow writes, frame request/status and the SPI pins.
// master = host logic, slave = the frame transmitter.

interface spi_frame_master_if;
  logic       wr_en;
  logic [4:0] wr_addr;
  logic [7:0] wr_data;
  logic       start;
  logic       busy;
  logic       done;
  logic       ss;
  logic       sclk;
  logic       mosi;

  modport master (
    output wr_en, wr_addr, wr_data, start,
    input  busy, done, ss, sclk, mosi
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, start,
    output busy, done, ss, sclk, mosi
  );
endinterface

// File: rtl/spi_frame_master.sv
// SPI mode-0 frame transmitter: sends the NUM_REGS-byte SID shadow, address order, MSB first.
// Optional SPI_AUTO_REFRESH_EN: any accepted shadow write queues a frame without start.

module spi_frame_master #(
  parameter int unsigned CLK_DIV  = 4,
  parameter int unsigned NUM_REGS = 25,
  parameter int unsigned SS_GAP   = 8
) (
  input logic               clk,
  input logic               rst,
  spi_frame_master_if.slave bus
);

  localparam int unsigned   AW       = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [7:0]    DivLast  = 8'(CLK_DIV - 1);
  localparam logic [7:0]    GapLast  = 8'(SS_GAP - 1);
  localparam logic [AW-1:0] LastByte = AW'(NUM_REGS - 1);

  localparam logic [2:0] StIdle = 3'd0;
  localparam logic [2:0] StLoad = 3'd1;
  localparam logic [2:0] StLow  = 3'd2;
  localparam logic [2:0] StHigh = 3'd3;
  localparam logic [2:0] StHold = 3'd4;
  localparam logic [2:0] StGap  = 3'd5;

  logic [7:0]    shadow_q [NUM_REGS];
  logic          shadow_we;
  logic [AW-1:0] wr_idx;

  assign shadow_we = bus.wr_en && (32'(bus.wr_addr) < NUM_REGS);
  assign wr_idx    = bus.wr_addr[AW-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) shadow_q[i] <= 8'h00;
    end else if (shadow_we) begin
      shadow_q[wr_idx] <= bus.wr_data;
    end
  end

  logic [2:0]    state_q, state_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [AW-1:0] byte_idx_q, byte_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          ss_q, ss_d;
  logic          sclk_q, sclk_d;
  logic          mosi_q, mosi_d;
  logic          pending_q, pending_d;
  logic          req, launch;
  logic [AW-1:0] byte_next;
  logic [7:0]    next_byte;

  assign byte_next = byte_idx_q + AW'(1);
  assign next_byte = shadow_q[byte_next];

`ifdef SPI_AUTO_REFRESH_EN
  logic dirty_q, dirty_d;

  assign req = bus.start | pending_q | dirty_q;

  // A write landing on the launch cycle is still picked up by this frame.
  always_comb begin
    dirty_d = dirty_q;
    if (launch)         dirty_d = 1'b0;
    else if (shadow_we) dirty_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) dirty_q <= 1'b0;
    else     dirty_q <= dirty_d;
  end
`else
  assign req = bus.start | pending_q;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_idx_d  = bit_idx_q;
    byte_idx_d = byte_idx_q;
    shift_d    = shift_q;
    ss_d       = ss_q;
    sclk_d     = sclk_q;
    mosi_d     = mosi_q;
    pending_d  = pending_q;
    launch     = 1'b0;

    // Only one request is ever queued; further starts merge into it.
    if (state_q != StIdle && bus.start) pending_d = 1'b1;

    case (state_q)
      StIdle: begin
        if (req) launch = 1'b1;
      end
      StLoad: begin
        byte_idx_d = '0;
        shift_d    = shadow_q[0];
        mosi_d     = shadow_q[0][7];
        bit_idx_d  = 3'd7;
        cnt_d      = 8'd0;
        state_d    = StLow;
      end
      StLow: begin
        if (cnt_q == DivLast) begin
          cnt_d   = 8'd0;
          sclk_d  = 1'b1;
          state_d = StHigh;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StHigh: begin
        if (cnt_q == DivLast) begin
          cnt_d  = 8'd0;
          sclk_d = 1'b0;
          if (bit_idx_q != 3'd0) begin
            shift_d   = {shift_q[6:0], 1'b0};
            mosi_d    = shift_q[6];
            bit_idx_d = bit_idx_q - 3'd1;
            state_d   = StLow;
          end else if (byte_idx_q != LastByte) begin
            byte_idx_d = byte_next;
            shift_d    = next_byte;
            mosi_d     = next_byte[7];
            bit_idx_d  = 3'd7;
            state_d    = StLow;
          end else begin
            state_d = StHold;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StHold: begin
        if (cnt_q == DivLast) begin
          cnt_d   = 8'd0;
          ss_d    = 1'b1;
          state_d = StGap;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StGap: begin
        if (cnt_q == GapLast) begin
          cnt_d   = 8'd0;
          state_d = StIdle;
          // A queued request chains straight into the next frame, keeping busy high.
          if (req) launch = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (launch) begin
      state_d   = StLoad;
      ss_d      = 1'b0;
      pending_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= 8'd0;
      bit_idx_q  <= 3'd0;
      byte_idx_q <= '0;
      shift_q    <= 8'h00;
      ss_q       <= 1'b1;
      sclk_q     <= 1'b0;
      mosi_q     <= 1'b0;
      pending_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_idx_q  <= bit_idx_d;
      byte_idx_q <= byte_idx_d;
      shift_q    <= shift_d;
      ss_q       <= ss_d;
      sclk_q     <= sclk_d;
      mosi_q     <= mosi_d;
      pending_q  <= pending_d;
    end
  end

  assign bus.busy = (state_q != StIdle);
  assign bus.done = (state_q == StGap) && (cnt_q == GapLast);
  assign bus.ss   = ss_q;
  assign bus.sclk = sclk_q;
  assign bus.mosi = mosi_q;

endmodule

// File: tb/tb_spi_frame_master.sv
// Bench for spi_frame_master: timing model of the default instance plus directed frame checks.

module tb_spi_frame_master;

  localparam int D  = 4;
  localparam int N  = 25;
  localparam int G  = 8;
  localparam int FB = 16 * D * N;
  localparam int L  = 1 + FB + D;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  spi_frame_master_if bus_a ();
  spi_frame_master_if bus_b ();

  spi_frame_master u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  spi_frame_master #(
    .CLK_DIV  (2),
    .NUM_REGS (1),
    .SS_GAP   (3)
  ) u_small (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: frame outputs as a function of cycles since the LOAD cycle.
  logic [7:0] m_shadow [32];
  logic [7:0] m_snap   [32];
  logic       m_valid = 1'b0;
  logic       m_busy  = 1'b0;
  logic       m_pend  = 1'b0;
  logic       m_dirty = 1'b0;
  int         m_cyc   = 0;
  int         m_t0    = 0;

  initial forever begin : model
    int k, b;
    logic [3:0] ev;
    logic [7:0] sb;
    logic req, sched, wacc;
    @(negedge clk);
    k = m_cyc - m_t0;
    if (m_valid) begin
      if (m_busy) begin
        if ((k % (16 * D)) == 0 && (k / (16 * D)) < N) m_snap[k / (16 * D)] = m_shadow[k / (16 * D)];
        ev = {k >= L, (k >= 1 && k < 1 + FB && ((k - 1) / D) % 2 == 1), 1'b1, k == L + G - 1};
      end else begin
        ev = 4'b1000;
      end
      chk("ctrl{ss,sclk,busy,done}",
          32'({bus_a.ss, bus_a.sclk, bus_a.busy, bus_a.done}), 32'(ev));
      if (m_busy && k >= 1 && k < 1 + FB) begin
        b  = (k - 1) / (2 * D);
        sb = m_snap[b / 8];
        chk("mosi", 32'(bus_a.mosi), 32'(sb[7 - b % 8]));
      end
    end
    if (rst) begin
      m_busy = 1'b0; m_pend = 1'b0; m_dirty = 1'b0; m_valid = 1'b1;
      for (int i = 0; i < 32; i++) m_shadow[i] = 8'h00;
    end else if (m_valid) begin
      req   = bus_a.start | m_pend | m_dirty;
      wacc  = bus_a.wr_en && (32'(bus_a.wr_addr) < N);
      sched = 1'b0;
      if (!m_busy) begin
        if (req) begin sched = 1'b1; m_busy = 1'b1; end
      end else if (k == L + G - 1) begin
        if (req) sched = 1'b1;
        else     m_busy = 1'b0;
      end else if (bus_a.start) begin
        m_pend = 1'b1;
      end
      if (sched) begin m_t0 = m_cyc + 1; m_pend = 1'b0; end
`ifdef SPI_AUTO_REFRESH_EN
      if (sched)     m_dirty = 1'b0;
      else if (wacc) m_dirty = 1'b1;
`endif
      if (wacc) m_shadow[bus_a.wr_addr] = bus_a.wr_data;
    end
    m_cyc++;
  end

  // Frame recorder for the default instance: length, edges, bytes, gap, launch latency.
  int         fr_cnt = 0;
  int         fr_len [16];
  int         fr_edges [16];
  int         fr_gap [16];
  int         fr_lat [16];
  logic [7:0] fr_bytes [16][32];
  int         mcyc = 0, cur_len = 0, cur_edges = 0, nbits = 0, rise_cyc = 0, last_done = -100000;
  logic       prev_ss = 1'b1, prev_sclk = 1'b0, in_frame = 1'b0;

  initial forever begin : monitor
    @(negedge clk);
    mcyc++;
    if (rst) begin
      in_frame = 1'b0; prev_ss = 1'b1; prev_sclk = 1'b0; last_done = -100000;
    end else begin
      if (!bus_a.ss) begin
        if (prev_ss && fr_cnt < 16) begin
          in_frame = 1'b1; cur_len = 0; cur_edges = 0; nbits = 0;
          fr_lat[fr_cnt] = mcyc - last_done;
          for (int i = 0; i < 32; i++) fr_bytes[fr_cnt][i] = 8'h00;
        end
        cur_len++;
        if (bus_a.sclk && !prev_sclk) begin
          cur_edges++;
          if (nbits < 256 && fr_cnt < 16)
            fr_bytes[fr_cnt][nbits / 8] = {fr_bytes[fr_cnt][nbits / 8][6:0], bus_a.mosi};
          nbits++;
        end
      end else if (!prev_ss && in_frame) begin
        if (fr_cnt < 16) begin fr_len[fr_cnt] = cur_len; fr_edges[fr_cnt] = cur_edges; end
        fr_cnt++; in_frame = 1'b0; rise_cyc = mcyc;
      end
      if (bus_a.done) begin
        last_done = mcyc;
        if (fr_cnt > 0 && fr_cnt <= 16) fr_gap[fr_cnt - 1] = mcyc - rise_cyc + 1;
      end
      prev_ss = bus_a.ss; prev_sclk = bus_a.sclk;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wr_a(input logic [4:0] a, input logic [7:0] d);
    bus_a.wr_en = 1'b1; bus_a.wr_addr = a; bus_a.wr_data = d;
    tick(1);
    bus_a.wr_en = 1'b0;
  endtask

  task automatic start_a();
    bus_a.start = 1'b1;
    tick(1);
    bus_a.start = 1'b0;
  endtask

  task automatic wait_frames(input int n, input int budget, input string name);
    int c = 0;
    while (fr_cnt < n && c < budget) begin tick(1); c++; end
    chk(name, 32'(fr_cnt >= n), 32'd1);
    tick(12);
  endtask

  function automatic int nonzero(input int f, input int lo, input int hi);
    int z = 0;
    for (int i = lo; i <= hi; i++) if (fr_bytes[f][i] != 8'h00) z++;
    return z;
  endfunction

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int lo, runs, bad, hr, edges, sd, base;
    logic [7:0] sb;
    logic pb;
    bus_a.wr_en = 1'b0; bus_a.wr_addr = 5'd0; bus_a.wr_data = 8'h00; bus_a.start = 1'b0;
    bus_b.wr_en = 1'b0; bus_b.wr_addr = 5'd0; bus_b.wr_data = 8'h00; bus_b.start = 1'b0;
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_a", 32'({bus_a.ss, bus_a.sclk, bus_a.mosi, bus_a.busy, bus_a.done}), 32'h10);
    chk("reset_b", 32'({bus_b.ss, bus_b.sclk, bus_b.mosi, bus_b.busy, bus_b.done}), 32'h10);
    tick(1);

    // CLK_DIV=2, NUM_REGS=1 instance: one byte 0x81.
    bus_b.wr_en = 1'b1; bus_b.wr_addr = 5'd0; bus_b.wr_data = 8'h81;
    tick(1);
    bus_b.wr_en = 1'b0; bus_b.start = 1'b1;
    tick(1);
    bus_b.start = 1'b0;
    lo = 0; runs = 0; bad = 0; hr = 0; edges = 0; sd = 0; sb = 8'h00; pb = 1'b0;
    repeat (80) begin
      @(negedge clk);
      if (!bus_b.ss) lo++;
      if (bus_b.sclk) begin
        if (!pb) begin edges++; sb = {sb[6:0], bus_b.mosi}; end
        hr++;
      end else if (pb) begin
        runs++; if (hr != 2) bad++; hr = 0;
      end
      pb = bus_b.sclk;
      if (bus_b.done) sd++;
    end
    tick(1);
    chk("small_ss_low", 32'(lo), 32'd35);
    chk("small_byte", 32'(sb), 32'h81);
    chk("small_edges", 32'(edges), 32'd8);
    chk("small_high_runs", 32'(runs), 32'd8);
    chk("small_high_not_2", 32'(bad), 32'd0);
    chk("small_done", 32'(sd), 32'd1);

    // Default frame: 0xA5 first, 0x3C last, out-of-range write ignored.
    wr_a(5'd0, 8'hA5);
    wr_a(5'd24, 8'h3C);
    wr_a(5'd31, 8'h77);
    start_a();
    wait_frames(1, 2000, "frame0_seen");
    chk("f0_ss_low", 32'(fr_len[0]), 32'd1605);
    chk("f0_edges", 32'(fr_edges[0]), 32'd200);
    chk("f0_byte0", 32'(fr_bytes[0][0]), 32'hA5);
    chk("f0_byte24", 32'(fr_bytes[0][24]), 32'h3C);
    chk("f0_mid_zero", 32'(nonzero(0, 1, 23)), 32'd0);
    chk("f0_gap_to_done", 32'(fr_gap[0]), 32'd8);

    // Merged starts plus a write to byte 2 while byte 5 shifts.
    base = fr_cnt;
    wr_a(5'd2, 8'h12);
    start_a();
    tick(100);
    start_a();
    tick(250);
    wr_a(5'd2, 8'h55);
    tick(300);
    start_a();
    tick(300);
    start_a();
    wait_frames(base + 2, 5000, "merged_frames_seen");
    chk("cur_frame_old_b2", 32'(fr_bytes[base][2]), 32'h12);
    chk("next_frame_new_b2", 32'(fr_bytes[base + 1][2]), 32'h55);
    chk("next_frame_b0", 32'(fr_bytes[base + 1][0]), 32'hA5);
    chk("chain_latency", 32'(fr_lat[base + 1]), 32'd1);
    tick(2000);
    chk("one_extra_frame", 32'(fr_cnt - base), 32'd2);

    // Reset at byte 10 bit 3, then a full all-zero frame.
    base = fr_cnt;
    start_a();
    tick(673);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    @(negedge clk);
    chk("midreset_outs", 32'({bus_a.ss, bus_a.sclk, bus_a.busy}), 32'h4);
    tick(1);
    chk("truncated_not_counted", 32'(fr_cnt - base), 32'd0);
    start_a();
    wait_frames(base + 1, 2000, "post_reset_frame_seen");
    chk("pr_ss_low", 32'(fr_len[base]), 32'd1605);
    chk("pr_edges", 32'(fr_edges[base]), 32'd200);
    chk("pr_all_zero", 32'(nonzero(base, 0, 24)), 32'd0);

    base = fr_cnt;
    wr_a(5'd3, 8'h11);
`ifdef SPI_AUTO_REFRESH_EN
    wait_frames(base + 1, 3000, "auto_frame_seen");
    chk("auto_b3", 32'(fr_bytes[base][3]), 32'h11);
    tick(2500);
    chk("auto_single", 32'(fr_cnt - base), 32'd1);
`else
    tick(2000);
    chk("no_auto_frame", 32'(fr_cnt - base), 32'd0);
    start_a();
    wait_frames(base + 1, 2000, "manual_frame_seen");
    chk("manual_b3", 32'(fr_bytes[base][3]), 32'h11);
`endif
    tick(5);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
